syn_wm8731_cfg_seq: RTL and testbench

//  Codec init sequencer, upstream of the I2C master. On a start pulse it walks a fixed
//  WM8731 register table and, per entry, programs the I2C master over its local-bus

---
 rtl/syn_wm8731_cfg_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_syn_wm8731_cfg_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_wm8731_cfg_seq.sv
// syn_wm8731_cfg_seq - WM8731 codec init sequencer.
//
// Walks a fixed WM8731 register table and programs a downstream I2C master
// over its local-bus slave port for each entry: device address, data word,
// trigger. It then polls STATUS until the transfer completes. A NACK retries
// the entry up to P_MAX_RETRY times before the run aborts.
//
// Ports:
//   clk_ir, rst_ir      clock, async active-high reset
//   cfg_start_ir        start pulse (ignored while busy)
//   cfg_busy_or         run in progress
//   cfg_done_or         sticky, last run completed
//   cfg_err_or          sticky, last run aborted on NACK
//   cfg_idx_or          current / last table index
//   i2cm_*              local-bus master: addr, wr/rd strobes, write data,
//                       wr/rd valid acks, read data
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for cfg_start_ir
// PRE_RD| read STATUS; a transfer may still be running from before reset
// PRE_GP| wait P_POLL_GAP cycles, then re-read STATUS
// WR_CDV| write CLK_DIV (once per run)
// WR_DEV| write device address
// WR_DAT| write table[idx]
// WR_TRG| write STATUS (starts the transfer, clears NACK)
// GAP   | wait P_POLL_GAP cycles so the master has left its idle state
// RD_ST | read STATUS: busy / ok / NACK
// NEXT  | advance idx or finish
// FIN   | run completed, drop busy, set done
// ABORT | retries exhausted, drop busy, set err
module syn_wm8731_cfg_seq #(
  parameter logic [7:0]  P_DEV_ADDR  = 8'h34,
  parameter logic [7:0]  P_CLK_DIV   = 8'hFF,
  parameter int unsigned P_POLL_GAP  = 4,
  parameter int unsigned P_MAX_RETRY = 3,
  parameter logic [7:0]  P_STAT_REG  = 8'h00,
  parameter logic [7:0]  P_ADDR_REG  = 8'h01,
  parameter logic [7:0]  P_DATA_REG  = 8'h02,
  parameter logic [7:0]  P_CDIV_REG  = 8'h03
) (
  input  logic        clk_ir,
  input  logic        rst_ir,
  input  logic        cfg_start_ir,
  output logic        cfg_busy_or,
  output logic        cfg_done_or,
  output logic        cfg_err_or,
  output logic [3:0]  cfg_idx_or,
  output logic [7:0]  i2cm_addr_or,
  output logic        i2cm_wr_en_or,
  output logic [15:0] i2cm_wr_data_or,
  output logic        i2cm_rd_en_or,
  input  logic        i2cm_wr_valid_ir,
  input  logic        i2cm_rd_valid_ir,
  input  logic [15:0] i2cm_rd_data_ir
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE_RD, S_PRE_GAP, S_WR_CDIV, S_WR_DEV, S_WR_DATA,
    S_WR_TRIG, S_GAP, S_RD_STAT, S_NEXT, S_FIN, S_ABORT
  } state_t;

  localparam logic [3:0] GAP_LAST  = 4'(P_POLL_GAP - 1);
  localparam logic [1:0] RETRY_MAX = 2'(P_MAX_RETRY);

  state_t      state_q, state_d;
  logic        pend_q, pend_d;     // strobe issued, waiting for its valid
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  retry_q, retry_d;
  logic [3:0]  gap_q, gap_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        wr_state;
  state_t      wr_next;
  logic        gap_state;
  state_t      gap_next;

  // Data word = {reg[6:0], val[8:0]}
  function automatic logic [15:0] tbl(input logic [3:0] i);
    case (i)
      4'd0:    tbl = {7'd15, 9'h000};
      4'd1:    tbl = {7'd6,  9'h010};
      4'd2:    tbl = {7'd0,  9'h017};
      4'd3:    tbl = {7'd1,  9'h017};
      4'd4:    tbl = {7'd4,  9'h012};
      4'd5:    tbl = {7'd5,  9'h000};
      4'd6:    tbl = {7'd7,  9'h042};
      4'd7:    tbl = {7'd8,  9'h000};
      4'd8:    tbl = {7'd9,  9'h001};
      default: tbl = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk_ir or posedge rst_ir) begin
    if (rst_ir) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      retry_q <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pend_d          = pend_q;
    idx_d           = idx_q;
    retry_d         = retry_q;
    gap_d           = '0;
    busy_d          = busy_q;
    done_d          = done_q;
    err_d           = err_q;
    i2cm_addr_or    = '0;
    i2cm_wr_data_or = '0;
    i2cm_wr_en_or   = 1'b0;
    i2cm_rd_en_or   = 1'b0;
    wr_state        = 1'b0;
    wr_next         = S_IDLE;
    gap_state       = 1'b0;
    gap_next        = S_IDLE;

    case (state_q)
      S_IDLE: begin
        if (cfg_start_ir) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          retry_d = '0;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = S_PRE_RD;
        end
      end
      S_PRE_RD, S_RD_STAT: begin
        i2cm_addr_or  = P_STAT_REG;
        i2cm_rd_en_or = ~pend_q;
        if (!pend_q) begin
          pend_d = 1'b1;
        end else if (i2cm_rd_valid_ir) begin
          pend_d = 1'b0;
          if (state_q == S_PRE_RD) begin
            state_d = i2cm_rd_data_ir[0] ? S_PRE_GAP : S_WR_CDIV;
          end else if (i2cm_rd_data_ir[0]) begin
            state_d = S_GAP;
          end else if (!i2cm_rd_data_ir[1]) begin
            state_d = S_NEXT;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
            state_d = S_WR_DEV;
          end else begin
            state_d = S_ABORT;
          end
        end
      end
      S_PRE_GAP: begin
        gap_state = 1'b1;
        gap_next  = S_PRE_RD;
      end
      S_WR_CDIV: begin
        wr_state        = 1'b1;
        wr_next         = S_WR_DEV;
        i2cm_addr_or    = P_CDIV_REG;
        i2cm_wr_data_or = {8'h00, P_CLK_DIV};
      end
      S_WR_DEV: begin
        wr_state        = 1'b1;
        wr_next         = S_WR_DATA;
        i2cm_addr_or    = P_ADDR_REG;
        i2cm_wr_data_or = {8'h00, P_DEV_ADDR};
      end
      S_WR_DATA: begin
        wr_state        = 1'b1;
        wr_next         = S_WR_TRIG;
        i2cm_addr_or    = P_DATA_REG;
        i2cm_wr_data_or = tbl(idx_q);
      end
      S_WR_TRIG: begin
        wr_state        = 1'b1;
        wr_next         = S_GAP;
        i2cm_addr_or    = P_STAT_REG;
        i2cm_wr_data_or = 16'h0000;
      end
      S_GAP: begin
        gap_state = 1'b1;
        gap_next  = S_RD_STAT;
      end
      S_NEXT: begin
        retry_d = '0;
        if (idx_q == 4'd8) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_WR_DEV;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        busy_d  = 1'b0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared write handshake: strobe once, hold addr/data until wr_valid.
    if (wr_state) begin
      i2cm_wr_en_or = ~pend_q;
      if (!pend_q) begin
        pend_d = 1'b1;
      end else if (i2cm_wr_valid_ir) begin
        pend_d  = 1'b0;
        state_d = wr_next;
      end
    end

    // Shared wait counter; saturates rather than wrapping.
    if (gap_state) begin
      if (gap_q >= GAP_LAST) begin
        state_d = gap_next;
      end else begin
        gap_d = (gap_q == 4'hF) ? gap_q : gap_q + 4'd1;
      end
    end
  end

  assign cfg_busy_or = busy_q;
  assign cfg_done_or = done_q;
  assign cfg_err_or  = err_q;
  assign cfg_idx_or  = idx_q;

endmodule

// File: tb/tb_syn_wm8731_cfg_seq.sv
module tb_syn_wm8731_cfg_seq;

  logic        clk_ir = 1'b0;
  logic        rst_ir;
  logic        cfg_start_ir;
  logic        cfg_busy_or, cfg_done_or, cfg_err_or;
  logic [3:0]  cfg_idx_or;
  logic [7:0]  i2cm_addr_or;
  logic        i2cm_wr_en_or, i2cm_rd_en_or;
  logic [15:0] i2cm_wr_data_or;
  logic        i2cm_wr_valid_ir = 1'b0;
  logic        i2cm_rd_valid_ir = 1'b0;
  logic [15:0] i2cm_rd_data_ir  = 16'h0000;

  always #5 clk_ir = ~clk_ir;

  syn_wm8731_cfg_seq dut (
    .clk_ir           (clk_ir),
    .rst_ir           (rst_ir),
    .cfg_start_ir     (cfg_start_ir),
    .cfg_busy_or      (cfg_busy_or),
    .cfg_done_or      (cfg_done_or),
    .cfg_err_or       (cfg_err_or),
    .cfg_idx_or       (cfg_idx_or),
    .i2cm_addr_or     (i2cm_addr_or),
    .i2cm_wr_en_or    (i2cm_wr_en_or),
    .i2cm_wr_data_or  (i2cm_wr_data_or),
    .i2cm_rd_en_or    (i2cm_rd_en_or),
    .i2cm_wr_valid_ir (i2cm_wr_valid_ir),
    .i2cm_rd_valid_ir (i2cm_rd_valid_ir),
    .i2cm_rd_data_ir  (i2cm_rd_data_ir)
  );

  // Hand-computed {reg[6:0], val[8:0]} words.
  localparam logic [15:0] EXP_TBL [9] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217,
                                          16'h0812, 16'h0A00, 16'h0E42, 16'h1000,
                                          16'h1201};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- bus slave model (owned by the negedge process) ----------
  // Settings written by the main process, applied when cfg_gen changes.
  int cfg_gen = 0, nack_entry = -1, nack_times = 0, pre_busy = 0;
  bit hold_data = 0;
  int inj_rd_req = 0, inj_wr_req = 0;

  int cfg_seen = 0, inj_rd_done = 0, inj_wr_done = 0;
  logic [7:0]  wa[$];
  logic [15:0] wd[$];
  int rd_cnt = 0, first_wr_rd = -1, hold_seen = 0, viol = 0;
  int busy_left = 0, entry_trig = 0;
  bit cur_nack = 0, hold_active = 0, wr_pend_m = 0, rd_pend_m = 0;
  bit prev_wr = 0, prev_rd = 0;
  logic [15:0] last_data = 0, rd_resp = 0;

  always @(negedge clk_ir) begin
    int entry;
    i2cm_wr_valid_ir = 1'b0;
    i2cm_rd_valid_ir = 1'b0;
    i2cm_rd_data_ir  = 16'h0000;
    if (cfg_gen != cfg_seen) begin
      cfg_seen    = cfg_gen;
      busy_left   = pre_busy;
      entry_trig  = 0;
      cur_nack    = 0;
      hold_active = hold_data;
    end
    if (rst_ir) begin
      wr_pend_m = 0;
      rd_pend_m = 0;
    end else begin
      if (wr_pend_m) begin i2cm_wr_valid_ir = 1'b1; wr_pend_m = 0; end
      if (inj_wr_req != inj_wr_done) begin
        i2cm_wr_valid_ir = 1'b1;
        inj_wr_done = inj_wr_req;
      end
      if (rd_pend_m) begin
        i2cm_rd_valid_ir = 1'b1;
        i2cm_rd_data_ir  = rd_resp;
        rd_pend_m = 0;
      end else if (inj_rd_req != inj_rd_done) begin
        i2cm_rd_valid_ir = 1'b1;
        i2cm_rd_data_ir  = 16'h0002;
        inj_rd_done = inj_rd_req;
      end
      if (i2cm_wr_en_or) begin
        if (prev_wr || wr_pend_m) viol++;
        if (first_wr_rd < 0) first_wr_rd = rd_cnt;
        wa.push_back(i2cm_addr_or);
        wd.push_back(i2cm_wr_data_or);
        if (i2cm_addr_or == 8'h02) last_data = i2cm_wr_data_or;
        if (i2cm_addr_or == 8'h00) begin
          busy_left = 3;
          entry = -1;
          for (int k = 0; k < 9; k++) if (EXP_TBL[k] == last_data) entry = k;
          cur_nack = 0;
          if (entry == nack_entry) begin
            cur_nack = (entry_trig < nack_times);
            entry_trig++;
          end
        end
        if (hold_active && i2cm_addr_or == 8'h02) hold_seen++;
        else wr_pend_m = 1;
      end
      if (i2cm_rd_en_or) begin
        if (prev_rd) viol++;
        rd_cnt++;
        if (busy_left > 0) begin
          rd_resp = 16'h0001;
          busy_left--;
        end else begin
          rd_resp = {14'b0, cur_nack, 1'b0};
        end
        rd_pend_m = 1;
      end
    end
    prev_wr = i2cm_wr_en_or;
    prev_rd = i2cm_rd_en_or;
  end

  // ---------------- main sequence ----------------
  task automatic tick();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic set_model(input int ne, input int nt, input int pb, input bit hd);
    nack_entry = ne;
    nack_times = nt;
    pre_busy   = pb;
    hold_data  = hd;
    cfg_gen++;
    tick();
    tick();
  endtask

  // Pulse start, then wait for busy to fall. stray=1 adds extra start pulses
  // and unsolicited rd_valid while the run is going.
  task automatic run(input string tag, input bit stray);
    bit fin = 0;
    cfg_start_ir = 1'b1;
    tick();
    cfg_start_ir = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (stray) begin
        cfg_start_ir = (i % 7 == 0);
        if (i % 3 == 0) inj_rd_req++;
      end
      tick();
      if (!cfg_busy_or) begin fin = 1; break; end
    end
    cfg_start_ir = 1'b0;
    chk({tag, "_finished"}, 32'(fin), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int base, input int ne,
                              input int nn, input int last);
    logic [23:0] ea[$];
    ea.push_back({8'h03, 16'h00FF});
    for (int k = 0; k <= last; k++) begin
      int reps = (k == ne) ? nn + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        ea.push_back({8'h01, 16'h0034});
        ea.push_back({8'h02, EXP_TBL[k]});
        ea.push_back({8'h00, 16'h0000});
      end
    end
    chk({tag, "_wr_count"}, 32'(wa.size() - base), 32'(ea.size()));
    for (int i = 0; i < ea.size(); i++)
      if (base + i < wa.size())
        chk($sformatf("%s_wr%0d", tag, i), {8'h00, wa[base+i], wd[base+i]}, {8'h00, ea[i]});
  endtask

  task automatic check_status(input string tag, input bit d, input bit e, input logic [3:0] idx);
    chk({tag, "_status"}, {25'b0, cfg_busy_or, cfg_done_or, cfg_err_or, cfg_idx_or},
        {25'b0, 1'b0, d, e, idx});
  endtask

  initial begin
    int wb, rb;
    bit seen;
    rst_ir = 1'b1;
    cfg_start_ir = 1'b0;
    repeat (3) @(posedge clk_ir);
    @(negedge clk_ir);
    chk("reset_outputs", {i2cm_wr_en_or, i2cm_rd_en_or, i2cm_addr_or, i2cm_wr_data_or,
                          cfg_busy_or, cfg_done_or, cfg_err_or, cfg_idx_or}, 32'd0);
    tick();
    rst_ir = 1'b0;
    tick();

    // 1: clean run
    set_model(-1, 0, 0, 0);
    wb = wa.size(); rb = rd_cnt;
    run("t1", 0);
    check_writes("t1", wb, -1, 0, 8);
    chk("t1_reads", 32'(rd_cnt - rb), 32'd37);
    check_status("t1", 1, 0, 4'd8);

    // 2: entry 2 NACKs twice, then ACKs
    set_model(2, 2, 0, 0);
    wb = wa.size();
    run("t2", 0);
    check_writes("t2", wb, 2, 2, 8);
    check_status("t2", 1, 0, 4'd8);

    // 3: entry 4 NACKs forever -> abort after 4 attempts
    set_model(4, 99, 0, 0);
    wb = wa.size();
    run("t3", 0);
    check_writes("t3", wb, 4, 3, 4);
    check_status("t3", 0, 1, 4'd4);
    repeat (30) tick();
    chk("t3_quiet", 32'(wa.size() - wb), 32'd25);

    // 4: master still busy at the first STATUS read
    set_model(-1, 0, 2, 0);
    wb = wa.size(); rb = rd_cnt;
    first_wr_rd = -1;
    run("t4", 0);
    chk("t4_reads_before_wr", 32'(first_wr_rd - rb), 32'd3);
    check_writes("t4", wb, -1, 0, 8);
    check_status("t4", 1, 0, 4'd8);

    // 5: stray starts and unsolicited rd_valid (with NACK data) during a run
    set_model(-1, 0, 0, 0);
    wb = wa.size(); rb = rd_cnt;
    run("t5", 1);
    chk("t5_wr_count", 32'(wa.size() - wb), 32'd28);
    chk("t5_reads", 32'(rd_cnt - rb), 32'd37);
    check_status("t5", 1, 0, 4'd8);

    // 6: reset while a DATA write waits for its ack
    set_model(-1, 0, 0, 1);
    rb = hold_seen;
    seen = 0;
    cfg_start_ir = 1'b1;
    tick();
    cfg_start_ir = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (hold_seen != rb) begin seen = 1; break; end
    end
    chk("t6_hold_reached", 32'(seen), 32'd1);
    rst_ir = 1'b1;
    @(negedge clk_ir);
    chk("t6_reset_outputs", {i2cm_wr_en_or, i2cm_rd_en_or, i2cm_addr_or, i2cm_wr_data_or,
                             cfg_busy_or, cfg_done_or, cfg_err_or, cfg_idx_or}, 32'd0);
    tick();
    rst_ir = 1'b0;
    wb = wa.size(); rb = rd_cnt;
    inj_wr_req++;
    repeat (12) tick();
    chk("t6_late_valid_ignored", {cfg_busy_or, 15'(wa.size() - wb), 16'(rd_cnt - rb)}, 32'd0);
    set_model(-1, 0, 0, 0);
    wb = wa.size();
    run("t6", 0);
    check_writes("t6", wb, -1, 0, 8);
    check_status("t6", 1, 0, 4'd8);

    chk("bus_strobe_rule", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
